biased_tile: RTL and testbench
==============================

BIASED_TILE -- requirements
Module: biased_tile

Interface
REQ-001 Parameter LEN, default 9: grid side length and one-hot value width, legal range 4..16.
REQ-002 Parameter CNT_W, default 5: width of the try counter; SHALL satisfy 2^CNT_W > LEN.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset is asynchronous and active-low.
REQ-005 myturn  input  1  one-cycle pulse granting this tile control of the search.
REQ-006 fromback  input  1  qualifies myturn: 0 = entered going forward, 1 = re-entered by backtrack.
REQ-007 givenvalid  input  1  load a fixed clue this cycle; honoured only in IDLE.
REQ-008 given  input  LEN  one-hot clue value, sampled with givenvalid.
REQ-009 rowbias  input  LEN  one-hot candidate returned for rqindex, valid one cycle after request.
REQ-010 occupiedmask  input  LEN  OR of values held by peer tiles in row/column/block.
REQ-011 rqindex  output  LEN+1  one-hot candidate index; bit LEN is the sentinel "exhausted" position.
REQ-012 value  output  LEN  one-hot current value; all-zero means empty.
REQ-013 fixed  output  1  tile holds a clue and is never searched.
REQ-014 passfwd  output  1  one-cycle pulse: value accepted, advance to next tile.
REQ-015 passbak  output  1  one-cycle pulse: no candidate left, backtrack to previous tile.
REQ-016 trycount  output  CNT_W  candidates tested since the last forward entry, saturating.

Function
REQ-017 States: IDLE, INCR, RQST, LOAD, PASSFWD, PASSBAK, FIXPASS.
REQ-018 IDLE: myturn & fixed -> FIXPASS; myturn & ~fixed -> INCR; else stay.
REQ-019 FIXPASS -> IDLE; asserts passfwd if the latched entry direction was forward, else passbak; value unchanged.
REQ-020 Forward entry of a non-fixed tile SHALL set rqindex to sentinel and trycount to 0 before INCR, so the search starts at index 0.
REQ-021 Backtrack entry SHALL retain rqindex and trycount, clear value to 0, and resume at the next index.
REQ-022 INCR: rqindex rotates up by one (bit LEN wraps to bit 0) -> RQST.
REQ-023 RQST: request presented; -> LOAD; rowbias is captured at the end of LOAD (one-cycle memory latency).
REQ-024 LOAD with rqindex[LEN]=1: value <= 0 -> PASSBAK.
REQ-025 LOAD with (rowbias & occupiedmask) != 0: trycount increments (saturates at all-ones) -> INCR.
REQ-026 LOAD otherwise: value <= rowbias, trycount increments -> PASSFWD.
REQ-027 PASSFWD and PASSBAK each last exactly one cycle and return to IDLE.
REQ-028 Best-case latency myturn to passfwd: 4 cycles; worst case LEN+1 candidate loops of 3 cycles + 1.
REQ-029 myturn outside IDLE SHALL be ignored; givenvalid outside IDLE SHALL be ignored.
REQ-030 givenvalid in IDLE: value <= given, fixed <= (given != 0); given = 0 clears fixed; if myturn coincides, load takes effect first and myturn uses the new fixed.
REQ-031 passfwd and passbak SHALL never be asserted together.

Reset
REQ-032 reset_n low SHALL asynchronously force IDLE, rqindex = sentinel, value = 0, fixed = 0, trycount = 0, passfwd = passbak = 0, mid-search included.
REQ-033 Deassertion SHALL be synchronised externally; block leaves IDLE only on the first myturn after release.

Structure
REQ-034 State enum, state width and the LEN default SHALL live in shared package sudoku_pkg, alongside the grid dimension constants.
REQ-035 Candidate index rotator and try counter SHALL form one sub-module, tile_idx_ctr (rotate, clear, hold, saturating count).

Verification
REQ-036 LEN=9, reset, myturn fwd, rowbias=1<<k for index k, occupiedmask=0 -> passfwd 4 cycles later, value=9'h001, trycount=1.
REQ-037 occupiedmask=9'h00F, same rowbias -> passfwd with value=9'h010, rqindex bit 4 set, trycount=5.
REQ-038 occupiedmask=9'h1FF -> passbak after 9 failed candidates plus sentinel, value=0, rqindex=sentinel, trycount=9.
REQ-039 After REQ-037, myturn with fromback=1, occupiedmask=9'h01F -> resumes at index 5, passfwd value=9'h020.
REQ-040 givenvalid with given=9'h080, then myturn fwd -> passfwd next cycle, value=9'h080, fixed=1, no rqindex change; myturn fromback -> passbak.
REQ-041 reset_n low during LOAD -> all outputs at reset values immediately, no pass pulse; myturn after release restarts search at index 0.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku solver tiles.
// Holds the grid dimensions, the default one-hot width for a tile and the
// tile search state encoding.
package sudoku_pkg;

   localparam int GRID_N   = 9;
   localparam int BLOCK_N  = 3;
   localparam int CELL_CNT = GRID_N * GRID_N;
   localparam int LEN_DEF  = GRID_N;
   localparam int STATE_W  = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE,
      ST_INCR,
      ST_RQST,
      ST_LOAD,
      ST_PASSFWD,
      ST_PASSBAK,
      ST_FIXPASS
   } tile_state_e;

endpackage

// File: rtl/biased_tile_if.sv
// Tile-facing bus: turn handshake, clue load, candidate memory port and
// peer occupancy, plus the tile's status outputs.
//   slave  : the tile itself
//   master : the sequencer / candidate memory / peers driving the tile
interface biased_tile_if
   import sudoku_pkg::*;
#(
   parameter int LEN   = LEN_DEF,
   parameter int CNT_W = 5
);
   logic             myturn;
   logic             fromback;
   logic             givenvalid;
   logic [LEN-1:0]   given;
   logic [LEN-1:0]   rowbias;
   logic [LEN-1:0]   occupiedmask;
   logic [LEN:0]     rqindex;
   logic [LEN-1:0]   value;
   logic             fixed;
   logic             passfwd;
   logic             passbak;
   logic [CNT_W-1:0] trycount;

   modport slave (
      input  myturn, fromback, givenvalid, given, rowbias, occupiedmask,
      output rqindex, value, fixed, passfwd, passbak, trycount
   );

   modport master (
      output myturn, fromback, givenvalid, given, rowbias, occupiedmask,
      input  rqindex, value, fixed, passfwd, passbak, trycount
   );
endinterface

// File: rtl/tile_idx_ctr.sv
// Candidate index rotator and saturating try counter for one tile.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   clear          : park the index on the sentinel and zero the count
//   rotate         : advance the one-hot index by one, sentinel wraps to 0
//   count_en       : count one tested candidate (saturates at all-ones)
//   rqindex        : one-hot index, bit LEN is the exhausted sentinel
//   trycount       : candidates tested since the last clear
module tile_idx_ctr #(
   parameter int LEN   = 9,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             rotate,
   input  logic             count_en,
   output logic [LEN:0]     rqindex,
   output logic [CNT_W-1:0] trycount
);

   localparam logic [LEN:0] SENTINEL = {1'b1, {LEN{1'b0}}};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rqindex  <= SENTINEL;
         trycount <= '0;
      end else if (clear) begin
         rqindex  <= SENTINEL;
         trycount <= '0;
      end else begin
         if (rotate)
            rqindex <= {rqindex[LEN-1:0], rqindex[LEN]};
         if (count_en && (trycount != '1))
            trycount <= trycount + CNT_W'(1);
      end
   end

endmodule

// File: rtl/biased_tile.sv
// One sudoku cell searching for a value not held by its peers, trying
// candidates in the order supplied by a row-biased candidate memory.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   bus            : biased_tile_if slave (turn handshake, clue load,
//                    candidate request/response, occupancy, status)
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for myturn; clue loads accepted here only
// ST_INCR     | advance candidate index
// ST_RQST     | candidate index presented to memory
// ST_LOAD     | memory response valid; accept, reject or give up
// ST_PASSFWD  | passfwd pulse, value accepted
// ST_PASSBAK  | passbak pulse, candidates exhausted
// ST_FIXPASS  | clue tile passes the turn straight through
module biased_tile
   import sudoku_pkg::*;
#(
   parameter int LEN   = LEN_DEF,
   parameter int CNT_W = 5
) (
   input  logic          clock,
   input  logic          reset_n,
   biased_tile_if.slave  bus
);

   tile_state_e      state;
   logic [LEN-1:0]   value;
   logic             fixed;
   logic             passfwd;
   logic             passbak;
   logic [LEN:0]     rqindex;
   logic [CNT_W-1:0] trycount;

   logic fixed_next;
   logic enter;
   logic clear;
   logic rotate;
   logic count_en;

   // A clue loaded in the same cycle as myturn decides how the turn is taken.
   assign fixed_next = (state == ST_IDLE && bus.givenvalid) ? (bus.given != '0) : fixed;
   assign enter      = (state == ST_IDLE) && bus.myturn;
   assign clear      = enter && !fixed_next && !bus.fromback;
   assign rotate     = (state == ST_INCR);
   assign count_en   = (state == ST_LOAD) && !rqindex[LEN];

   tile_idx_ctr #(.LEN(LEN), .CNT_W(CNT_W)) u_idx_ctr (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (clear),
      .rotate   (rotate),
      .count_en (count_en),
      .rqindex  (rqindex),
      .trycount (trycount)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         value   <= '0;
         fixed   <= 1'b0;
         passfwd <= 1'b0;
         passbak <= 1'b0;
      end else begin
         passfwd <= 1'b0;
         passbak <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.givenvalid) begin
                  value <= bus.given;
                  fixed <= (bus.given != '0);
               end
               if (bus.myturn) begin
                  if (fixed_next) begin
                     state   <= ST_FIXPASS;
                     passfwd <= !bus.fromback;
                     passbak <= bus.fromback;
                  end else begin
                     state <= ST_INCR;
                     if (bus.fromback)
                        value <= '0;
                  end
               end
            end
            ST_INCR: state <= ST_RQST;
            ST_RQST: state <= ST_LOAD;
            ST_LOAD: begin
               if (rqindex[LEN]) begin
                  value   <= '0;
                  state   <= ST_PASSBAK;
                  passbak <= 1'b1;
               end else if ((bus.rowbias & bus.occupiedmask) != '0) begin
                  state <= ST_INCR;
               end else begin
                  value   <= bus.rowbias;
                  state   <= ST_PASSFWD;
                  passfwd <= 1'b1;
               end
            end
            ST_PASSFWD: state <= ST_IDLE;
            ST_PASSBAK: state <= ST_IDLE;
            ST_FIXPASS: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rqindex  = rqindex;
   assign bus.value    = value;
   assign bus.fixed    = fixed;
   assign bus.passfwd  = passfwd;
   assign bus.passbak  = passbak;
   assign bus.trycount = trycount;

endmodule

// File: tb/tb_biased_tile.sv
// Directed bench for biased_tile with LEN=9, CNT_W=5.
// The candidate memory returns 1<<k for one-hot index k, one cycle late.
module tb_biased_tile;

   logic clock = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clock = ~clock;

   biased_tile_if #(.LEN(9), .CNT_W(5)) bif ();

   biased_tile #(.LEN(9), .CNT_W(5)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bif.slave)
   );

   always @(posedge clock) bif.rowbias <= bif.rqindex[8:0];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_turn(input logic back);
      bif.myturn   = 1'b1;
      bif.fromback = back;
      @(negedge clock);
      bif.myturn   = 1'b0;
      bif.fromback = 1'b0;
   endtask

   task automatic wait_pass(input int start, input int budget,
                            output int lat, output logic f, output logic b);
      lat = start;
      while (lat < budget && !(bif.passfwd || bif.passbak)) begin
         @(negedge clock);
         lat++;
      end
      f = bif.passfwd;
      b = bif.passbak;
      if (!(f || b)) lat = -1;
   endtask

   task automatic turn(input logic back, output int lat, output logic f, output logic b);
      @(negedge clock);
      pulse_turn(back);
      wait_pass(1, 60, lat, f, b);
   endtask

   task automatic check_status(input string tag, input logic [31:0] val,
                               input logic [31:0] rq, input logic [31:0] tc);
      check({tag, "_value"}, bif.value, val);
      check({tag, "_rqindex"}, bif.rqindex, rq);
      check({tag, "_trycount"}, bif.trycount, tc);
   endtask

   initial begin
      int   lat;
      logic f, b;

      reset_n          = 1'b0;
      bif.myturn       = 1'b0;
      bif.fromback     = 1'b0;
      bif.givenvalid   = 1'b0;
      bif.given        = '0;
      bif.occupiedmask = '0;
      repeat (3) @(negedge clock);
      check_status("rst", 32'h000, 32'h200, 0);
      check("rst_fixed", bif.fixed, 0);
      check("rst_pass", {bif.passfwd, bif.passbak}, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check("idle_nopass", {bif.passfwd, bif.passbak}, 0);

      // first candidate accepted
      bif.occupiedmask = 9'h000;
      turn(1'b0, lat, f, b);
      check("a_lat", lat, 4);
      check("a_pass", {f, b}, 2'b10);
      check_status("a", 32'h001, 32'h001, 1);
      @(negedge clock);
      check("a_pulse_len", {bif.passfwd, bif.passbak}, 0);

      // four occupied candidates skipped
      bif.occupiedmask = 9'h00F;
      turn(1'b0, lat, f, b);
      check("b_lat", lat, 16);
      check("b_pass", {f, b}, 2'b10);
      check_status("b", 32'h010, 32'h010, 5);

      // backtrack re-entry resumes at the next index
      bif.occupiedmask = 9'h01F;
      turn(1'b1, lat, f, b);
      check("c_lat", lat, 4);
      check("c_pass", {f, b}, 2'b10);
      check_status("c", 32'h020, 32'h020, 6);

      // everything occupied: exhaust to the sentinel
      bif.occupiedmask = 9'h1FF;
      turn(1'b0, lat, f, b);
      check("d_lat", lat, 31);
      check("d_pass", {f, b}, 2'b01);
      check_status("d", 32'h000, 32'h200, 9);

      // repeated backtracks drive the try counter into saturation
      turn(1'b1, lat, f, b);
      check("e1_pass", {f, b}, 2'b01);
      check("e1_trycount", bif.trycount, 18);
      turn(1'b1, lat, f, b);
      check("e2_trycount", bif.trycount, 27);
      turn(1'b1, lat, f, b);
      check("e3_lat", lat, 31);
      check("e3_trycount", bif.trycount, 31);

      // myturn and givenvalid mid-search are ignored
      bif.occupiedmask = 9'h00F;
      @(negedge clock);
      pulse_turn(1'b0);
      repeat (2) @(negedge clock);
      bif.myturn     = 1'b1;
      bif.fromback   = 1'b1;
      bif.givenvalid = 1'b1;
      bif.given      = 9'h100;
      @(negedge clock);
      bif.myturn     = 1'b0;
      bif.fromback   = 1'b0;
      bif.givenvalid = 1'b0;
      bif.given      = '0;
      wait_pass(4, 60, lat, f, b);
      check("f_lat", lat, 16);
      check("f_pass", {f, b}, 2'b10);
      check("f_fixed", bif.fixed, 0);
      check_status("f", 32'h010, 32'h010, 5);

      // clue tile passes straight through in either direction
      @(negedge clock);
      bif.givenvalid = 1'b1;
      bif.given      = 9'h080;
      @(negedge clock);
      bif.givenvalid = 1'b0;
      bif.given      = '0;
      check("g_fixed", bif.fixed, 1);
      check("g_value_load", bif.value, 32'h080);
      turn(1'b0, lat, f, b);
      check("g_fwd_lat", lat, 1);
      check("g_fwd_pass", {f, b}, 2'b10);
      check_status("g", 32'h080, 32'h010, 5);
      turn(1'b1, lat, f, b);
      check("g_bak_lat", lat, 1);
      check("g_bak_pass", {f, b}, 2'b01);
      check("g_bak_value", bif.value, 32'h080);

      // clearing clue coinciding with myturn: the clear wins, search runs
      bif.occupiedmask = 9'h000;
      @(negedge clock);
      bif.givenvalid = 1'b1;
      bif.given      = 9'h000;
      pulse_turn(1'b0);
      bif.givenvalid = 1'b0;
      check("h_fixed", bif.fixed, 0);
      wait_pass(1, 60, lat, f, b);
      check("h_lat", lat, 4);
      check("h_pass", {f, b}, 2'b10);
      check_status("h", 32'h001, 32'h001, 1);

      // reset asserted during LOAD
      bif.occupiedmask = 9'h00F;
      @(negedge clock);
      pulse_turn(1'b0);
      repeat (2) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_status("i_rst", 32'h000, 32'h200, 0);
      check("i_rst_fixed", bif.fixed, 0);
      check("i_rst_pass", {bif.passfwd, bif.passbak}, 0);
      repeat (2) @(negedge clock);
      check("i_rst_hold", {bif.passfwd, bif.passbak}, 0);
      reset_n = 1'b1;
      bif.occupiedmask = 9'h000;
      turn(1'b0, lat, f, b);
      check("i_lat", lat, 4);
      check("i_pass", {f, b}, 2'b10);
      check_status("i", 32'h001, 32'h001, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
